// File: rtl/masked_aes_pkg.sv
// Shared definitions for the masked block/word stream adapter: sender FSM
// states and the beat-count / index-width helpers used to size counters.
package masked_aes_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int beats(input int block_w, input int word_w);
    return block_w / word_w;
  endfunction

  // Width of a counter able to hold values 0..n-1 (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/masked_stream_adapter_if.sv
// Block-input, core-word and result-output signals of masked_stream_adapter.
// master = surrounding system / core, slave = the adapter.
interface masked_stream_adapter_if #(
  parameter int NSHARES = 2,
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NSHARES*BLOCK_W-1:0]  in_data;
  logic [NSHARES*BLOCK_W-1:0]  in_key;
  logic [NSHARES*WORD_W-1:0]   core_data;
  logic [NSHARES*WORD_W-1:0]   core_key;
  logic                        core_first;
  logic                        core_done;
  logic [NSHARES*WORD_W-1:0]   core_out;
  logic                        out_valid;
  logic                        out_ready;
  logic [NSHARES*BLOCK_W-1:0]  out_data;
  logic                        err;

  modport master (
    output in_valid, in_data, in_key, core_done, core_out, out_ready,
    input  in_ready, core_data, core_key, core_first, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, in_key, core_done, core_out, out_ready,
    output in_ready, core_data, core_key, core_first, out_valid, out_data, err
  );
endinterface

// File: rtl/share_block_fifo.sv
// In-order buffer of shared result blocks; out_data reads zero while empty.
// A push into a full buffer is taken when a pop happens in the same cycle.
module share_block_fifo
  import masked_aes_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int BLOCK_W = 128,
  parameter int DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [NSHARES*BLOCK_W-1:0]    push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          out_valid,
  output logic [NSHARES*BLOCK_W-1:0]    out_data,
  output logic [idx_w(DEPTH+1)-1:0]     count
);
  localparam int W  = NSHARES * BLOCK_W;
  localparam int AW = idx_w(DEPTH);
  localparam int CW = idx_w(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign do_pop    = pop && out_valid;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/masked_stream_adapter.sv
// Splits shared blocks into MSW-first words for a non-stallable masked core and
// reassembles its results into a credit-protected FIFO. Optional MASK_REFRESH_EN.
module masked_stream_adapter
  import masked_aes_pkg::*;
#(
  parameter int NSHARES = 2,
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int DEPTH   = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef MASK_REFRESH_EN
  input  logic [(NSHARES-1)*WORD_W-1:0] rnd,
`endif
  masked_stream_adapter_if.slave bus
);
  localparam int BEATS = beats(BLOCK_W, WORD_W);
  localparam int BW    = idx_w(BEATS);
  localparam int CW    = idx_w(DEPTH + 1);
  localparam int DW    = NSHARES * BLOCK_W;
  localparam int WW    = NSHARES * WORD_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  if (BLOCK_W % WORD_W != 0 || BLOCK_W / WORD_W < 2) begin : g_bad_block_cfg
    $error("masked_stream_adapter: BLOCK_W must be a multiple of WORD_W holding at least two words");
  end
  if (NSHARES < 2 || DEPTH < 1) begin : g_bad_share_cfg
    $error("masked_stream_adapter: NSHARES must be >= 2 and DEPTH >= 1");
  end

  function automatic logic [WW-1:0] top_words(input logic [DW-1:0] b);
    logic [WW-1:0] w;
    w = '0;
    for (int unsigned s = 0; s < NSHARES; s++)
      w[s*WORD_W +: WORD_W] = b[s*BLOCK_W + BLOCK_W - WORD_W +: WORD_W];
    return w;
  endfunction

  function automatic logic [DW-1:0] shift_block(input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < NSHARES; s++)
      r[s*BLOCK_W +: BLOCK_W] = b[s*BLOCK_W +: BLOCK_W] << WORD_W;
    return r;
  endfunction

  function automatic logic [DW-1:0] low_words(input logic [WW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < NSHARES; s++)
      r[s*BLOCK_W +: WORD_W] = w[s*WORD_W +: WORD_W];
    return r;
  endfunction

  // ---------------- block -> word sender ----------------
  state_t        state;
  logic [BW-1:0] beat;
  logic [DW-1:0] blk_data, blk_key;
  logic          last_beat, credit_ok, accept;
  logic [CW-1:0] in_flight, occ;
  logic [CW:0]   committed;

  assign last_beat    = (state == SEND) && (beat == BW'(BEATS - 1));
  assign committed    = {1'b0, in_flight} + {1'b0, occ};
  assign credit_ok    = committed < DEPTH_C;
  assign bus.in_ready = !rst && (state == IDLE || last_beat) && credit_ok;
  assign accept       = bus.in_valid && bus.in_ready;

  // Remaining words are kept left-aligned so the next one is always at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= '0;
      blk_data       <= '0;
      blk_key        <= '0;
      bus.core_data  <= '0;
      bus.core_key   <= '0;
      bus.core_first <= 1'b0;
    end else if (accept) begin
      state          <= SEND;
      beat           <= '0;
      blk_data       <= shift_block(bus.in_data);
      blk_key        <= shift_block(bus.in_key);
      bus.core_data  <= top_words(bus.in_data);
      bus.core_key   <= top_words(bus.in_key);
      bus.core_first <= 1'b1;
    end else if (state == SEND && !last_beat) begin
      beat           <= beat + 1'b1;
      blk_data       <= shift_block(blk_data);
      blk_key        <= shift_block(blk_key);
      bus.core_data  <= top_words(blk_data);
      bus.core_key   <= top_words(blk_key);
      bus.core_first <= 1'b0;
    end else begin
      state          <= IDLE;
      beat           <= '0;
      bus.core_data  <= '0;
      bus.core_key   <= '0;
      bus.core_first <= 1'b0;
    end
  end

  // ---------------- word -> block capture ----------------
  logic          capturing, start, discard, push, pop, fifo_full, fifo_valid;
  logic [BW-1:0] cap_beat;
  logic [DW-1:0] cap_buf, push_data, fifo_data;
  logic [WW-1:0] cap_word;

`ifdef MASK_REFRESH_EN
  logic [WORD_W-1:0] rnd_sum;
  always_comb begin
    rnd_sum  = '0;
    cap_word = bus.core_out;
    for (int unsigned j = 0; j < NSHARES - 1; j++) begin
      cap_word[j*WORD_W +: WORD_W] = bus.core_out[j*WORD_W +: WORD_W] ^ rnd[j*WORD_W +: WORD_W];
      rnd_sum = rnd_sum ^ rnd[j*WORD_W +: WORD_W];
    end
    cap_word[(NSHARES-1)*WORD_W +: WORD_W] = bus.core_out[(NSHARES-1)*WORD_W +: WORD_W] ^ rnd_sum;
  end
`else
  assign cap_word = bus.core_out;
`endif

  assign pop       = fifo_valid && bus.out_ready;
  assign start     = bus.core_done && !capturing && (!fifo_full || pop);
  assign discard   = bus.core_done && !start;
  assign push      = capturing && (cap_beat == BW'(BEATS - 1));
  assign push_data = shift_block(cap_buf) | low_words(cap_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      capturing <= 1'b0;
      cap_beat  <= '0;
      cap_buf   <= '0;
      bus.err   <= 1'b0;
    end else begin
      if (start) begin
        capturing <= 1'b1;
        cap_beat  <= BW'(1);
        cap_buf   <= low_words(cap_word);
      end else if (capturing) begin
        cap_buf <= push_data;
        if (push) begin
          capturing <= 1'b0;
          cap_beat  <= '0;
        end else begin
          cap_beat <= cap_beat + 1'b1;
        end
      end
      if (discard) bus.err <= 1'b1;
    end
  end

  // A discarded result never reserved a credit, so only real pushes return one.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else if (accept && !push) begin
      in_flight <= in_flight + 1'b1;
    end else if (push && !accept && in_flight != '0) begin
      in_flight <= in_flight - 1'b1;
    end
  end

  share_block_fifo #(
    .NSHARES (NSHARES),
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (occ)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data;

endmodule
